// File: rtl/tile_cmd_scheduler.sv
// tile_cmd_scheduler: accepts TILE commands and dispatches each to a free compute engine round-robin,
// tracking busy engines from tile_done and keeping issue/complete counters for the host.
module tile_cmd_scheduler #(
   parameter int NUM_CE = 4,
   parameter int CE_W   = $clog2(NUM_CE)
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_cmd_valid,
   output logic              o_cmd_ready,
   input  logic [15:0]       i_cmd_left_addr,
   input  logic [15:0]       i_cmd_right_addr,
   input  logic [7:0]        i_cmd_left_ugd_len,
   input  logic [7:0]        i_cmd_right_ugd_len,
   input  logic [7:0]        i_cmd_vec_len,
   input  logic [2:0]        i_cmd_flags,
   output logic [NUM_CE-1:0] o_ce_tile_en,
   output logic [15:0]       o_ce_left_addr,
   output logic [15:0]       o_ce_right_addr,
   output logic [7:0]        o_ce_left_ugd_len,
   output logic [7:0]        o_ce_right_ugd_len,
   output logic [7:0]        o_ce_vec_len,
   output logic [2:0]        o_ce_flags,
   input  logic [NUM_CE-1:0] i_ce_tile_done,
   input  logic              i_drain,
   output logic [NUM_CE-1:0] o_ce_busy,
   output logic              o_all_idle,
   output logic              o_zero_dim_drop,
   output logic              o_err_spurious_done,
   output logic [15:0]       o_tiles_issued,
   output logic [15:0]       o_tiles_done
);
   typedef enum logic {IDLE, ISSUE} state_t;
   state_t state;
   logic [NUM_CE-1:0] busy, tile_en_q, own_issue, done_ok, sel_oh;
   logic [CE_W-1:0] rr_ptr, sel, idx;
   logic [15:0] done_cnt;
   logic accept, zero_dim;
   // first free engine at or after rr_ptr; the descending scan lets the nearest one win
   always_comb begin
      sel = '0;
      idx = '0;
      for (int i = NUM_CE - 1; i >= 0; i--) begin
         idx = CE_W'((int'(rr_ptr) + i) % NUM_CE);
         if (!busy[idx]) sel = idx;
      end
   end
   // a done on the engine being started this very cycle belongs to no tile
   always_comb begin
      own_issue = (state == ISSUE) ? tile_en_q : '0;
      done_ok = i_ce_tile_done & busy & ~own_issue;
      done_cnt = '0;
      for (int i = 0; i < NUM_CE; i++) done_cnt = done_cnt + 16'(done_ok[i]);
   end
   assign sel_oh       = NUM_CE'(1) << sel;
   assign zero_dim     = ~|i_cmd_left_ugd_len || ~|i_cmd_right_ugd_len || ~|i_cmd_vec_len;
   assign o_cmd_ready  = (state == IDLE) && !i_drain && !(&busy);
   assign accept       = i_cmd_valid && o_cmd_ready;
   assign o_all_idle   = ~|busy && (state == IDLE);
   assign o_ce_busy    = busy;
   assign o_ce_tile_en = tile_en_q & {NUM_CE{~i_reset}};
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state               <= IDLE;
         busy                <= '0;
         rr_ptr              <= '0;
         tile_en_q           <= '0;
         o_zero_dim_drop     <= 1'b0;
         o_err_spurious_done <= 1'b0;
         o_tiles_issued      <= '0;
         o_tiles_done        <= '0;
         o_ce_left_addr      <= '0;
         o_ce_right_addr     <= '0;
         o_ce_left_ugd_len   <= '0;
         o_ce_right_ugd_len  <= '0;
         o_ce_vec_len        <= '0;
         o_ce_flags          <= '0;
      end else begin
         tile_en_q       <= '0;
         o_zero_dim_drop <= accept && zero_dim;
         busy            <= (busy & ~done_ok) | ((accept && !zero_dim) ? sel_oh : '0);
         o_tiles_done    <= o_tiles_done + done_cnt;
         if (|(i_ce_tile_done & ~(busy & ~own_issue))) o_err_spurious_done <= 1'b1;
         if (state == ISSUE) begin
            state          <= IDLE;
            o_tiles_issued <= o_tiles_issued + 16'd1;
         end
         if (accept) begin
            o_ce_left_addr     <= i_cmd_left_addr;
            o_ce_right_addr    <= i_cmd_right_addr;
            o_ce_left_ugd_len  <= i_cmd_left_ugd_len;
            o_ce_right_ugd_len <= i_cmd_right_ugd_len;
            o_ce_vec_len       <= i_cmd_vec_len;
            o_ce_flags         <= i_cmd_flags;
            if (!zero_dim) begin
               tile_en_q <= sel_oh;
               rr_ptr    <= (sel == CE_W'(NUM_CE - 1)) ? '0 : sel + 1'b1;
               state     <= ISSUE;
            end
         end
      end
   end
endmodule

// File: tb/tb_tile_cmd_scheduler.sv
// tb_tile_cmd_scheduler: directed commands push expected {drop, tile_en} events into a queue;
// a negedge monitor pops and compares whenever the scheduler pulses an output.
module tb_tile_cmd_scheduler;
   logic clk = 0, rst = 1, valid = 0, drain = 0;
   logic ready, all_idle, drop, err;
   logic [15:0] la = 0, ra = 0, ce_la, ce_ra, issued, done_n;
   logic [7:0] b = 0, c = 0, v = 0, ce_b, ce_c, ce_v;
   logic [2:0] f = 0, ce_f;
   logic [3:0] tile_en, busy, done = 0;
   logic [4:0] exp_q[$];
   int n_chk = 0, n_pass = 0;
   always #5 clk = ~clk;
   tile_cmd_scheduler dut (
      .i_clk(clk), .i_reset(rst), .i_cmd_valid(valid), .o_cmd_ready(ready),
      .i_cmd_left_addr(la), .i_cmd_right_addr(ra), .i_cmd_left_ugd_len(b),
      .i_cmd_right_ugd_len(c), .i_cmd_vec_len(v), .i_cmd_flags(f),
      .o_ce_tile_en(tile_en), .o_ce_left_addr(ce_la), .o_ce_right_addr(ce_ra),
      .o_ce_left_ugd_len(ce_b), .o_ce_right_ugd_len(ce_c), .o_ce_vec_len(ce_v),
      .o_ce_flags(ce_f), .i_ce_tile_done(done), .i_drain(drain), .o_ce_busy(busy),
      .o_all_idle(all_idle), .o_zero_dim_drop(drop), .o_err_spurious_done(err),
      .o_tiles_issued(issued), .o_tiles_done(done_n)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_chk++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, want);
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic send(input logic [15:0] l, input logic [15:0] r, input logic [7:0] nb,
                       input logic [7:0] nc, input logic [7:0] nv, input logic [2:0] nf,
                       input logic [4:0] want, input logic expect_evt);
      int n = 0;
      la = l; ra = r; b = nb; c = nc; v = nv; f = nf; valid = 1;
      #0;
      while (!ready && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) chk("ready_timeout", 0, 1);
      if (expect_evt) exp_q.push_back(want);
      step();
      valid = 0;
   endtask
   task automatic done_pulse(input logic [3:0] m);
      done = m;
      step();
      done = 0;
   endtask
   always @(negedge clk) begin
      if (tile_en != 0 || drop) begin
         if (exp_q.size() == 0) chk("unexpected_event", {drop, tile_en}, 0);
         else chk("event", {drop, tile_en}, exp_q.pop_front());
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
   initial begin
      step();
      chk("rst_idle", all_idle, 1);
      chk("rst_tile_en", tile_en, 0);
      step();
      rst = 0;
      #1;
      chk("rst_ready", ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_cnt", {issued, done_n}, 0);
      chk("rst_err", {err, drop}, 0);
      // T1
      send(16'h1000, 16'h2000, 2, 3, 4, 3'b101, 5'b00001, 1);
      chk("t1_ready_low", ready, 0);
      chk("t1_busy", busy, 4'b0001);
      chk("t1_latch", {ce_la, ce_ra, ce_b, ce_c, ce_v, 5'(ce_f)}, {16'h1000, 16'h2000, 8'd2, 8'd3, 8'd4, 5'b00101});
      step();
      chk("t1_ready_high", ready, 1);
      chk("t1_issued", issued, 1);
      done_pulse(4'b0001);
      chk("t1_done", done_n, 1);
      chk("t1_idle", {all_idle, busy}, 5'b10000);
      // T2
      rst = 1;
      step();
      rst = 0;
      chk("t2_rst_cnt", {issued, done_n}, 0);
      send(16'h0010, 16'h0020, 1, 1, 1, 0, 5'b00001, 1);
      send(16'h0011, 16'h0021, 1, 1, 1, 0, 5'b00010, 1);
      send(16'h0012, 16'h0022, 1, 1, 1, 0, 5'b00100, 1);
      send(16'h0013, 16'h0023, 1, 1, 1, 0, 5'b01000, 1);
      step();
      valid = 1;
      for (int i = 0; i < 3; i++) begin
         chk("t2_stall_ready", ready, 0);
         step();
      end
      chk("t2_busy_full", busy, 4'b1111);
      chk("t2_issued4", issued, 4);
      done = 4'b0100;
      step();
      done = 0;
      send(16'h0014, 16'h0024, 1, 1, 1, 0, 5'b00100, 1);
      step();
      chk("t2_cnt", {issued, done_n}, {16'd5, 16'd1});
      done_pulse(4'b1000);
      send(16'h0015, 16'h0025, 1, 1, 1, 0, 5'b01000, 1);
      step();
      done_pulse(4'b1011);
      send(16'h0016, 16'h0026, 1, 1, 1, 0, 5'b00001, 1);
      send(16'h0017, 16'h0027, 1, 1, 1, 0, 5'b00010, 1);
      step();
      done_pulse(4'b0011);
      chk("t3_setup_busy", busy, 4'b0100);
      // T3
      done = 4'b0100;
      send(16'h0018, 16'h0028, 1, 1, 1, 0, 5'b01000, 1);
      done = 0;
      chk("t3_busy", busy, 4'b1000);
      step();
      chk("t3_cnt", {issued, done_n}, {16'd9, 16'd8});
      // T4
      send(16'h0019, 16'h0029, 5, 5, 0, 0, 5'b10000, 1);
      chk("t4_ready", ready, 1);
      step();
      chk("t4_issued", issued, 9);
      chk("t4_busy", busy, 4'b1000);
      // T5
      done_pulse(4'b1000);
      chk("t5_no_err", err, 0);
      done_pulse(4'b0010);
      chk("t5_err", err, 1);
      chk("t5_done_cnt", done_n, 9);
      step();
      step();
      chk("t5_err_sticky", err, 1);
      // T6
      send(16'h0030, 16'h0040, 1, 1, 1, 0, 5'b00001, 1);
      send(16'h0031, 16'h0041, 1, 1, 1, 0, 5'b00010, 1);
      step();
      drain = 1;
      #1;
      chk("t6_drain_ready", ready, 0);
      valid = 1;
      step();
      step();
      valid = 0;
      done_pulse(4'b0001);
      chk("t6_not_idle", all_idle, 0);
      done_pulse(4'b0010);
      chk("t6_idle", all_idle, 1);
      chk("t6_cnt", {issued, done_n}, {16'd11, 16'd11});
      drain = 0;
      send(16'h0032, 16'h0042, 1, 1, 1, 0, 5'b00100, 1);
      drain = 1;
      step();
      chk("t6_mid_issue_ready", ready, 0);
      chk("t6_mid_issued", issued, 12);
      drain = 0;
      #1;
      chk("t6_undrain_ready", ready, 1);
      done_pulse(4'b0100);
      // done on an engine during its own issue cycle
      rst = 1;
      step();
      rst = 0;
      send(16'h0050, 16'h0060, 1, 1, 1, 0, 5'b00001, 1);
      done = 4'b0001;
      step();
      done = 0;
      chk("own_done_busy", busy, 4'b0001);
      chk("own_done_err", err, 1);
      chk("own_done_cnt", done_n, 0);
      // reset during ISSUE suppresses the pulse
      send(16'h0051, 16'h0061, 1, 1, 1, 0, 5'b00010, 0);
      rst = 1;
      step();
      rst = 0;
      chk("rst_issue_busy", busy, 0);
      chk("rst_issue_cnt", {issued, done_n}, 0);
      chk("rst_issue_flags", {all_idle, err}, 2'b10);
      step();
      step();
      chk("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
